// File: rtl/bj_video_pkg.sv
// Shared definitions for the background tile fetch path: FSM states,
// tile-RAM area bases and attribute byte layout.
package bj_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CODE = 2'd1,
        ST_ATTR = 2'd2,
        ST_WAIT = 2'd3
    } fetch_state_t;

    localparam int unsigned CODE_BASE = 'h000;
    localparam int unsigned ATTR_BASE = 'h400;

    localparam int unsigned ATTR_COLOR_LSB = 0;
    localparam int unsigned ATTR_COLOR_MSB = 3;
    localparam int unsigned ATTR_BANK      = 4;
    localparam int unsigned ATTR_FLIPY     = 6;
    localparam int unsigned ATTR_FLIPX     = 7;

endpackage

// File: rtl/tile_addr_gen.sv
// Maps the pixel column/line of the next tile to its code and attribute
// addresses in tile RAM, honouring screen flip.
module tile_addr_gen
    import bj_video_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic [4:0]        col_pix,
    input  logic [4:0]        row_pix,
    input  logic              flip,
    output logic [ADDR_W-1:0] code_addr,
    output logic [ADDR_W-1:0] attr_addr
);

    logic [4:0] col;
    logic [4:0] row;

    always_comb begin
        // fetch runs one tile ahead of the pixel being drawn
        col = col_pix + 5'd1;
        row = row_pix;
        if (flip) begin
            col = ~col;
            row = ~row;
        end
        code_addr = ADDR_W'(CODE_BASE) | ADDR_W'({row, col});
        attr_addr = ADDR_W'(ATTR_BASE) | ADDR_W'({row, col});
    end

endmodule

// File: rtl/char_fetch.sv
// Background character fetcher: reads code and attribute bytes for the next
// tile and presents them as registered tile outputs at the tile boundary.
module char_fetch
    import bj_video_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              vblank,
    input  logic              flip_screen,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [8:0]        tile_code,
    output logic [3:0]        tile_color,
    output logic              tile_flipx,
    output logic [2:0]        tile_row,
    output logic              tile_valid,
    output logic              overrun
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] code_addr;
    logic [ADDR_W-1:0] attr_addr;
    logic [ADDR_W-1:0] attr_addr_hold;
    logic [DATA_W-1:0] pend_code;
    logic [DATA_W-1:0] pend_attr;
    logic              pend_valid;
    logic              vblank_d;
    logic              trigger;
    logic              promote;
    logic              unused_bits;

    assign trigger     = ce_pix && (hpos[2:0] == 3'd0) && !vblank;
    assign promote     = ce_pix && (hpos[2:0] == 3'd7);
    assign unused_bits = ^{hpos[8], vpos[8], pend_attr[5]};

    tile_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .col_pix   (hpos[7:3]),
        .row_pix   (vpos[7:3]),
        .flip      (flip_screen),
        .code_addr (code_addr),
        .attr_addr (attr_addr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ram_en         <= 1'b0;
            ram_addr       <= '0;
            attr_addr_hold <= '0;
            pend_code      <= '0;
            pend_attr      <= '0;
            pend_valid     <= 1'b0;
            overrun        <= 1'b0;
            vblank_d       <= 1'b0;
        end else begin
            vblank_d <= vblank;

            if (vblank && !vblank_d)
                overrun <= 1'b0;
            else if (trigger && state != ST_IDLE)
                overrun <= 1'b1;

            // completion beats the promotion clear so a fresh result survives
            if (state == ST_WAIT)
                pend_valid <= 1'b1;
            else if (promote)
                pend_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state          <= ST_CODE;
                        ram_en         <= 1'b1;
                        ram_addr       <= code_addr;
                        attr_addr_hold <= attr_addr;
                    end
                end
                ST_CODE: begin
                    state    <= ST_ATTR;
                    ram_addr <= attr_addr_hold;
                end
                ST_ATTR: begin
                    state     <= ST_WAIT;
                    ram_en    <= 1'b0;
                    pend_code <= ram_q;
                end
                ST_WAIT: begin
                    state     <= ST_IDLE;
                    pend_attr <= ram_q;
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_code  <= '0;
            tile_color <= '0;
            tile_flipx <= 1'b0;
            tile_row   <= '0;
            tile_valid <= 1'b0;
        end else if (promote) begin
            if (pend_valid) begin
                tile_code  <= {pend_attr[ATTR_BANK], pend_code[7:0]};
                tile_color <= pend_attr[ATTR_COLOR_MSB:ATTR_COLOR_LSB];
                tile_flipx <= pend_attr[ATTR_FLIPX] ^ flip_screen;
                tile_row   <= vpos[2:0] ^ {3{pend_attr[ATTR_FLIPY] ^ flip_screen}};
                tile_valid <= 1'b1;
            end else begin
                tile_code  <= '0;
                tile_color <= '0;
                tile_flipx <= 1'b0;
                tile_row   <= '0;
                tile_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_char_fetch.sv
// Self-checking bench for char_fetch: timeline model of fetches plus directed
// literal checks for the main scenarios.
module tb_char_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_pix = 1'b0;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        vblank = 1'b0;
    logic        flip_screen = 1'b0;
    logic        ram_en;
    logic [10:0] ram_addr;
    logic [7:0]  ram_q = '0;
    logic [8:0]  tile_code;
    logic [3:0]  tile_color;
    logic        tile_flipx;
    logic [2:0]  tile_row;
    logic        tile_valid;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    logic [7:0] mem [0:2047];

    char_fetch #(.ADDR_W(11), .DATA_W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .hpos        (hpos),
        .vpos        (vpos),
        .vblank      (vblank),
        .flip_screen (flip_screen),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_q       (ram_q),
        .tile_code   (tile_code),
        .tile_color  (tile_color),
        .tile_flipx  (tile_flipx),
        .tile_row    (tile_row),
        .tile_valid  (tile_valid),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // synchronous-read tile RAM
    always @(posedge clock) if (ram_en) ram_q <= mem[ram_addr];

    // Model: each fetch is a timeline anchored at its trigger edge fs.
    int          e = 0;
    int          fs = 0;
    bit          fact = 1'b0;
    int          f_code = 0;
    int          f_attr = 0;
    logic        m_ram_en = 1'b0;
    logic [10:0] m_ram_addr = '0;
    logic        m_pend_valid = 1'b0;
    logic [7:0]  m_pend_code = '0;
    logic [7:0]  m_pend_attr = '0;
    logic [8:0]  m_tile_code = '0;
    logic [3:0]  m_tile_color = '0;
    logic        m_tile_flipx = 1'b0;
    logic [2:0]  m_tile_row = '0;
    logic        m_tile_valid = 1'b0;
    logic        m_overrun = 1'b0;
    logic        m_vb_prev = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fact = 0; m_ram_en = 0; m_ram_addr = '0;
            m_pend_valid = 0; m_pend_code = '0; m_pend_attr = '0;
            m_tile_code = '0; m_tile_color = '0; m_tile_flipx = 0;
            m_tile_row = '0; m_tile_valid = 0; m_overrun = 0; m_vb_prev = 0;
        end else begin
            bit busy;
            bit trig;
            int col, row;
            e++;
            busy = fact;
            trig = ce_pix && (hpos[2:0] == 3'd0) && !vblank;
            if (ce_pix && hpos[2:0] == 3'd7) begin
                if (m_pend_valid) begin
                    m_tile_code  = 9'(m_pend_attr[4] * 256 + m_pend_code);
                    m_tile_color = m_pend_attr[3:0];
                    m_tile_flipx = m_pend_attr[7] ^ flip_screen;
                    m_tile_row   = (m_pend_attr[6] ^ flip_screen) ? 3'(7 - vpos[2:0]) : vpos[2:0];
                    m_tile_valid = 1;
                end else begin
                    m_tile_code = '0; m_tile_color = '0; m_tile_flipx = 0;
                    m_tile_row = '0; m_tile_valid = 0;
                end
                m_pend_valid = 0;
            end
            if (fact) begin
                if (e == fs + 1) m_ram_addr = 11'(f_attr);
                if (e == fs + 2) m_ram_en = 0;
                if (e == fs + 3) begin
                    m_pend_valid = 1;
                    m_pend_code  = mem[f_code];
                    m_pend_attr  = mem[f_attr];
                    fact = 0;
                end
            end
            if (vblank && !m_vb_prev) m_overrun = 0;
            else if (trig && busy) m_overrun = 1;
            if (trig && !busy) begin
                col = (int'(hpos[7:3]) + 1) % 32;
                row = int'(vpos[7:3]);
                if (flip_screen) begin
                    col = 31 - col;
                    row = 31 - row;
                end
                f_code = row * 32 + col;
                f_attr = 1024 + f_code;
                fs = e;
                fact = 1;
                m_ram_en = 1;
                m_ram_addr = 11'(f_code);
            end
            m_vb_prev = vblank;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ram_en",     32'(ram_en),     32'(m_ram_en));
            chk("ram_addr",   32'(ram_addr),   32'(m_ram_addr));
            chk("tile_code",  32'(tile_code),  32'(m_tile_code));
            chk("tile_color", 32'(tile_color), 32'(m_tile_color));
            chk("tile_flipx", 32'(tile_flipx), 32'(m_tile_flipx));
            chk("tile_row",   32'(tile_row),   32'(m_tile_row));
            chk("tile_valid", 32'(tile_valid), 32'(m_tile_valid));
            chk("overrun",    32'(overrun),    32'(m_overrun));
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic run_h(input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            hpos = 9'(h);
            tick();
        end
    endtask

    task automatic basic_fetch(input string tag);
        vpos = 9'd16; flip_screen = 0; vblank = 0; ce_pix = 1;
        hpos = 9'd0; tick();
        chk({tag, "_en0"},   32'(ram_en),   32'd1);
        chk({tag, "_code_addr"}, 32'(ram_addr), 32'h041);
        hpos = 9'd1; tick();
        chk({tag, "_attr_addr"}, 32'(ram_addr), 32'h441);
        run_h(2, 7);
        chk({tag, "_tile_code"},  32'(tile_code),  32'h15A);
        chk({tag, "_tile_color"}, 32'(tile_color), 32'd3);
        chk({tag, "_tile_flipx"}, 32'(tile_flipx), 32'd1);
        chk({tag, "_tile_row"},   32'(tile_row),   32'd0);
        chk({tag, "_tile_valid"}, 32'(tile_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 5);
        mem[11'h041] = 8'h5A; mem[11'h441] = 8'h93;
        mem[11'h040] = 8'h12; mem[11'h440] = 8'h21;
        mem[11'h3FE] = 8'hA7; mem[11'h7FE] = 8'h05;

        repeat (3) tick();
        chk("rst_ram_en",     32'(ram_en),     32'd0);
        chk("rst_ram_addr",   32'(ram_addr),   32'd0);
        chk("rst_tile_code",  32'(tile_code),  32'd0);
        chk("rst_tile_valid", 32'(tile_valid), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        reset_n = 1;
        cmp_en = 1;
        tick();

        basic_fetch("basic");

        // column wrap: hpos 248 -> col 0 of row 2
        hpos = 9'd248; tick();
        chk("wrap_addr", 32'(ram_addr), 32'h040);
        run_h(249, 255);
        chk("wrap_tile_code", 32'(tile_code), 32'h012);

        // screen flip
        flip_screen = 1; vpos = 9'd0;
        hpos = 9'd0; tick();
        chk("flip_addr", 32'(ram_addr), 32'h3FE);
        run_h(1, 7);
        chk("flip_tile_row",   32'(tile_row),   32'd7);
        chk("flip_tile_flipx", 32'(tile_flipx), 32'd1);
        chk("flip_tile_code",  32'(tile_code),  32'h0A7);
        chk("flip_tile_color", 32'(tile_color), 32'd5);
        flip_screen = 0;

        // overrun: second trigger two clocks after the first
        vpos = 9'd16;
        hpos = 9'd0; tick();
        hpos = 9'd1; tick();
        hpos = 9'd0; tick();
        chk("ovr_set",    32'(overrun),  32'd1);
        chk("ovr_ram_en", 32'(ram_en),   32'd0);
        chk("ovr_addr",   32'(ram_addr), 32'h441);
        run_h(1, 7);
        chk("ovr_tile_code", 32'(tile_code), 32'h15A);
        chk("ovr_hold",      32'(overrun),   32'd1);
        vblank = 1;
        hpos = 9'd0; tick();
        chk("ovr_clear", 32'(overrun), 32'd0);
        chk("vb_no_fetch", 32'(ram_en), 32'd0);

        // vblank line: no fetch, promotion blanks the tile
        run_h(1, 7);
        chk("vb_tile_valid", 32'(tile_valid), 32'd0);
        chk("vb_tile_code",  32'(tile_code),  32'd0);
        vblank = 0;

        // reset while in ATTR
        run_h(0, 7);
        chk("pre_rst_valid", 32'(tile_valid), 32'd1);
        hpos = 9'd0; tick();
        hpos = 9'd1; tick();
        reset_n = 0;
        #1;
        chk("mid_rst_ram_en",     32'(ram_en),     32'd0);
        chk("mid_rst_ram_addr",   32'(ram_addr),   32'd0);
        chk("mid_rst_tile_code",  32'(tile_code),  32'd0);
        chk("mid_rst_tile_color", 32'(tile_color), 32'd0);
        chk("mid_rst_tile_flipx", 32'(tile_flipx), 32'd0);
        chk("mid_rst_tile_valid", 32'(tile_valid), 32'd0);
        hpos = 9'd2; tick();
        reset_n = 1;
        run_h(3, 7);
        chk("post_rst_valid", 32'(tile_valid), 32'd0);
        basic_fetch("rerun");

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
